// File: rtl/tdm_demux_pkg.sv
// Shared constants and FSM encoding for the 1-to-8 TDM demultiplexer.
package tdm_demux_pkg;

    localparam int N_CH  = 8;
    localparam int SEL_W = 3;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

endpackage

// File: rtl/demux_1_2.sv
// 1-to-2 demux cell: steers 'in' to a (s=0) or b (s=1).
// Combinational, zero latency; no flow control.
module demux_1_2 (
    input  logic in,
    input  logic s,
    output logic a,
    output logic b
);

    assign a = ~s & in;
    assign b =  s & in;

endmodule

// File: rtl/tdm_demux_1x8.sv
// Registered 1-to-8 TDM demux: external select or slot counter locked to frame_sync.
// Latency 1 cycle (sample at edge N visible with strobe at N+1); no backpressure, every valid sample is consumed or discarded.
module tdm_demux_1x8
    import tdm_demux_pkg::*;
#(
    parameter int DATA_W = 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [DATA_W-1:0]        din,
    input  logic                     din_valid,
    input  logic                     frame_sync,
    input  logic                     auto_mode,
    input  logic [SEL_W-1:0]         s,
    output logic [N_CH*DATA_W-1:0]   dout,
    output logic [N_CH-1:0]          dout_valid,
    output logic                     frame_done,
    output logic                     frame_err
);

    state_t             state, state_nxt;
    logic [SEL_W-1:0]   cnt, cnt_nxt;
    logic [SEL_W-1:0]   sel;
    logic               wr_en;
    logic               done_nxt;
    logic               err_nxt;
    logic [1:0]         wr_l1;
    logic [3:0]         wr_l2;
    logic [N_CH-1:0]    wr_vec;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        sel       = s;
        wr_en     = 1'b0;
        done_nxt  = 1'b0;
        err_nxt   = 1'b0;
        if (!auto_mode) begin
            // Manual mode also re-arms sync hunting for the next switch to auto.
            state_nxt = ST_IDLE;
            cnt_nxt   = '0;
            wr_en     = din_valid;
        end else if (din_valid) begin
            case (state)
                ST_IDLE: begin
                    if (frame_sync) begin
                        wr_en     = 1'b1;
                        sel       = '0;
                        cnt_nxt   = 3'd1;
                        state_nxt = ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (frame_sync) begin
                        // Sync always restarts at slot 0; early sync is a resync error.
                        wr_en   = 1'b1;
                        sel     = '0;
                        cnt_nxt = 3'd1;
                        err_nxt = (cnt != '0);
                    end else if (cnt != '0) begin
                        wr_en    = 1'b1;
                        sel      = cnt;
                        cnt_nxt  = cnt + 3'd1;
                        done_nxt = (cnt == 3'd7);
                    end else begin
                        err_nxt   = 1'b1;
                        cnt_nxt   = '0;
                        state_nxt = ST_IDLE;
                    end
                end
                default: begin
                    state_nxt = ST_IDLE;
                    cnt_nxt   = '0;
                end
            endcase
        end
    end

    // Write-enable decode tree: s[2] at the root, s[0] at the leaves.
    demux_1_2 u_root (.in(wr_en), .s(sel[2]), .a(wr_l1[0]), .b(wr_l1[1]));

    for (genvar i = 0; i < 2; i++) begin : g_mid
        demux_1_2 u_mid (.in(wr_l1[i]), .s(sel[1]), .a(wr_l2[2*i]), .b(wr_l2[2*i+1]));
    end

    for (genvar j = 0; j < 4; j++) begin : g_leaf
        demux_1_2 u_leaf (.in(wr_l2[j]), .s(sel[0]), .a(wr_vec[2*j]), .b(wr_vec[2*j+1]));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dout       <= '0;
            dout_valid <= '0;
            frame_done <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            for (int k = 0; k < N_CH; k++) begin
                if (wr_vec[k]) begin
                    dout[k*DATA_W +: DATA_W] <= din;
                end
            end
            dout_valid <= wr_vec;
            frame_done <= done_nxt;
            frame_err  <= err_nxt;
        end
    end

endmodule
